// File: rtl/ccd_patgen_pkg.sv
// Shared types and constants for the CCD pixel-bus pattern generator.
// Blob cell decoding is only used when CCD_PATGEN_BLOB_EN is defined.
package ccd_patgen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        ACTIVE,
        HBLANK,
        TRAIL,
        FRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_FLAT  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_COUNT = 2'd3
    } pattern_t;

    localparam logic [3:0] NO_BLOB = 4'd9;

    // Index (0..2) of the 3-way cell containing pos; 3 means past the last whole cell.
    function automatic logic [1:0] cell_of(input logic [15:0] pos, input int size);
        if (pos < 16'(size))          return 2'd0;
        else if (pos < 16'(2 * size)) return 2'd1;
        else if (pos < 16'(3 * size)) return 2'd2;
        else                          return 2'd3;
    endfunction

endpackage

// File: rtl/ccd_patgen_pixel.sv
// Pixel value for one (x, y) position from the frame's sampled pattern.
// CCD_PATGEN_BLOB_EN adds the 3x3 "finger blob" override.
module ccd_patgen_pixel
    import ccd_patgen_pkg::*;
`ifdef CCD_PATGEN_BLOB_EN
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [11:0] BLOB_LEVEL = 12'h000
)
`endif
(
`ifdef CCD_PATGEN_BLOB_EN
    input  logic [3:0]  grid,
`endif
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  pattern_t    pattern,
    input  logic [11:0] count,
    output logic [11:0] value
);

    logic [11:0] pat_value;

    always_comb begin
        unique case (pattern)
            PAT_FLAT:  pat_value = 12'h800;
            PAT_RAMP:  pat_value = x[11:0];
            PAT_CHECK: pat_value = (x[0] ^ y[0]) ? 12'hFFF : 12'h000;
            PAT_COUNT: pat_value = count;
            default:   pat_value = 12'h800;
        endcase
    end

`ifdef CCD_PATGEN_BLOB_EN
    localparam int CELL_W = H_ACTIVE / 3;
    localparam int CELL_H = V_ACTIVE / 3;

    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] cell;
    logic       in_blob;

    assign col  = cell_of(x, CELL_W);
    assign row  = cell_of(y, CELL_H);
    assign cell = 4'(row) * 4'd3 + 4'(col);
    // Remainder strips (index 3) never match; grid >= NO_BLOB exceeds every cell index.
    assign in_blob = (row != 2'd3) && (col != 2'd3) && (cell == grid) && (grid < NO_BLOB);
    assign value   = in_blob ? BLOB_LEVEL : pat_value;
`else
    logic unused_bits;
    assign unused_bits = ^{x[15:12], y[15:1]};
    assign value       = pat_value;
`endif

endmodule

// File: rtl/ccd_patgen.sv
// D5M-style FVAL/LVAL/data pattern generator: frame FSM, timing counters, registered outputs.
// Optional blob overlay is enabled with the CCD_PATGEN_BLOB_EN macro.
module ccd_patgen
    import ccd_patgen_pkg::*;
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          H_BLANK    = 16,
    parameter int          FV_LEAD    = 2,
    parameter int          FV_TRAIL   = 2,
    parameter int          V_FRONT    = 4,
    parameter logic [11:0] BLOB_LEVEL = 12'h000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iPATTERN,
    input  logic [3:0]  iGRID,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam logic [15:0] LEAD_LAST   = 16'(FV_LEAD - 1);
    localparam logic [15:0] H_LAST      = 16'(H_ACTIVE - 1);
    localparam logic [15:0] V_LAST      = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] TRAIL_LAST  = 16'(FV_TRAIL - 1);
    localparam logic [15:0] FRONT_LAST  = 16'(V_FRONT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] line, line_nxt;
    logic        stop_pend, stop_pend_nxt;
    pattern_t    pattern, pattern_nxt;
    logic [11:0] pix_cnt, pix_cnt_nxt;
    logic [31:0] frame_nxt;
    logic        load_cfg;
    logic        fval_nxt, lval_nxt, busy_nxt;
    logic [15:0] x_nxt, y_nxt;
    logic [11:0] pix_value, data_nxt;

`ifdef CCD_PATGEN_BLOB_EN
    logic [3:0]  grid, grid_nxt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{iGRID, BLOB_LEVEL};
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + 16'd1;
        line_nxt      = line;
        stop_pend_nxt = stop_pend | iSTOP;
        frame_nxt     = oFrame_Cont;
        load_cfg      = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt       = '0;
                stop_pend_nxt = 1'b0;
                if (iSTART && !iSTOP) begin
                    state_nxt = LEAD;
                    load_cfg  = 1'b1;
                end
            end
            LEAD: if (cnt == LEAD_LAST) begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
            ACTIVE: if (cnt == H_LAST) begin
                state_nxt = (line == V_LAST) ? TRAIL : HBLANK;
                cnt_nxt   = '0;
            end
            HBLANK: if (cnt == HBLANK_LAST) begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
                line_nxt  = line + 16'd1;
            end
            TRAIL: if (cnt == TRAIL_LAST) begin
                state_nxt = FRONT;
                cnt_nxt   = '0;
                frame_nxt = oFrame_Cont + 32'd1;
            end
            FRONT: if (cnt == FRONT_LAST) begin
                cnt_nxt = '0;
                if (stop_pend || iSTOP) begin
                    state_nxt     = IDLE;
                    stop_pend_nxt = 1'b0;
                end else begin
                    state_nxt = LEAD;
                    load_cfg  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pattern_nxt = load_cfg ? pattern_t'(iPATTERN) : pattern;
`ifdef CCD_PATGEN_BLOB_EN
        grid_nxt    = load_cfg ? iGRID : grid;
`endif
        // The counter value is the one shown on the upcoming pixel, then it advances.
        if (state_nxt == LEAD)        pix_cnt_nxt = '0;
        else if (state_nxt == ACTIVE) pix_cnt_nxt = pix_cnt + 12'd1;
        else                          pix_cnt_nxt = pix_cnt;

        lval_nxt = (state_nxt == ACTIVE);
        fval_nxt = state_nxt inside {LEAD, ACTIVE, HBLANK, TRAIL};
        busy_nxt = (state_nxt != IDLE);
        x_nxt    = lval_nxt ? cnt_nxt  : 16'd0;
        y_nxt    = lval_nxt ? line_nxt : 16'd0;
        data_nxt = lval_nxt ? pix_value : 12'd0;
    end

    ccd_patgen_pixel
`ifdef CCD_PATGEN_BLOB_EN
    #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BLOB_LEVEL (BLOB_LEVEL)
    )
`endif
    u_pixel (
`ifdef CCD_PATGEN_BLOB_EN
        .grid    (grid_nxt),
`endif
        .x       (x_nxt),
        .y       (y_nxt),
        .pattern (pattern_nxt),
        .count   (pix_cnt),
        .value   (pix_value)
    );

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            cnt         <= '0;
            line        <= '0;
            stop_pend   <= 1'b0;
            pattern     <= PAT_FLAT;
            pix_cnt     <= '0;
`ifdef CCD_PATGEN_BLOB_EN
            grid        <= '0;
`endif
            oDATA       <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            line        <= line_nxt;
            stop_pend   <= stop_pend_nxt;
            pattern     <= pattern_nxt;
            pix_cnt     <= pix_cnt_nxt;
`ifdef CCD_PATGEN_BLOB_EN
            grid        <= grid_nxt;
`endif
            oDATA       <= data_nxt;
            oFVAL       <= fval_nxt;
            oLVAL       <= lval_nxt;
            oX_Cont     <= x_nxt;
            oY_Cont     <= y_nxt;
            oFrame_Cont <= frame_nxt;
            oBUSY       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ccd_patgen.sv
// Directed bench for ccd_patgen with a 6x3 frame (period 30 cycles from LEAD entry).
// Cycle c is the clock period after posedge c; outputs are sampled 1 time unit after that edge.
module tb_ccd_patgen;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic        iSTOP = 1'b0;
    logic [1:0]  iPATTERN = 2'd0;
    logic [3:0]  iGRID = 4'd0;
    logic [11:0] oDATA;
    logic        oFVAL, oLVAL, oBUSY;
    logic [15:0] oX_Cont, oY_Cont;
    logic [31:0] oFrame_Cont;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    ccd_patgen #(
        .H_ACTIVE (6), .V_ACTIVE (3), .H_BLANK (2),
        .FV_LEAD (2), .FV_TRAIL (2), .V_FRONT (4), .BLOB_LEVEL (12'h000)
    ) dut (
        .iCLK (iCLK), .iRST (iRST), .iSTART (iSTART), .iSTOP (iSTOP),
        .iPATTERN (iPATTERN), .iGRID (iGRID),
        .oDATA (oDATA), .oFVAL (oFVAL), .oLVAL (oLVAL),
        .oX_Cont (oX_Cont), .oY_Cont (oY_Cont),
        .oFrame_Cont (oFrame_Cont), .oBUSY (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fval"},  32'(oFVAL), 0);
        check({tag, "_lval"},  32'(oLVAL), 0);
        check({tag, "_data"},  32'(oDATA), 0);
        check({tag, "_x"},     32'(oX_Cont), 0);
        check({tag, "_y"},     32'(oY_Cont), 0);
        check({tag, "_frame"}, oFrame_Cont, 0);
        check({tag, "_busy"},  32'(oBUSY), 0);
    endtask

    // Reset for two cycles, then release; the release cycle becomes cycle 0.
    task automatic do_reset();
        iRST = 1'b1;
        iSTART = 1'b0;
        iSTOP = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        iRST = 1'b0;
        cyc = 0;
    endtask

    // Expected bus position at rel cycles after LEAD entry (LEAD 2, lines at 2/10/18, TRAIL ends at 26).
    task automatic frame_pos(input int rel, output bit fv, output bit lv, output int x, output int y);
        fv = (rel < 26);
        lv = 1'b0;
        x = 0;
        y = 0;
        for (int l = 0; l < 3; l++) begin
            if (rel >= 2 + 8 * l && rel < 8 + 8 * l) begin
                lv = 1'b1;
                x = rel - 2 - 8 * l;
                y = l;
            end
        end
    endtask

    initial begin
        bit fv, lv;
        int x, y, rel, f;
        int exp_data;

        // Basic timing, flat frame then ramp frame; a start mid-frame is ignored.
        do_reset();
        iPATTERN = 2'd0;
        run_to(10);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        while (cyc <= 72) begin
            rel = (cyc - 11) % 30;
            f = (cyc - 11) / 30;
            frame_pos(rel, fv, lv, x, y);
            exp_data = !lv ? 0 : (f == 0) ? 32'h800 : x;
            check("a_fval", 32'(oFVAL), 32'(fv));
            check("a_lval", 32'(oLVAL), 32'(lv));
            check("a_x", 32'(oX_Cont), x);
            check("a_y", 32'(oY_Cont), y);
            check("a_data", 32'(oDATA), exp_data);
            check("a_frame", oFrame_Cont, f + ((rel >= 26) ? 1 : 0));
            check("a_busy", 32'(oBUSY), 1);
            if (cyc == 20) iPATTERN = 2'd1;
            iSTART = (cyc == 25);
            tick();
        end
        iSTART = 1'b0;

        // Reset mid-line, then a clean restart with the pixel counter pattern.
        do_reset();
        iPATTERN = 2'd3;
        run_to(10);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        run_to(14);
        check("b_data14", 32'(oDATA), 1);
        check("b_x14", 32'(oX_Cont), 1);
        run_to(15);
        iRST = 1'b1;
        tick();
        check_all_zero("b_midreset");
        iRST = 1'b0;
        run_to(20);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        check("b_fval21", 32'(oFVAL), 1);
        while (cyc <= 36) begin
            frame_pos(cyc - 21, fv, lv, x, y);
            check("b_lval", 32'(oLVAL), 32'(lv));
            check("b_data", 32'(oDATA), lv ? y * 6 + x : 0);
            check("b_frame", oFrame_Cont, 0);
            tick();
        end

        // Stop request mid-frame lets the frame finish, then idles.
        do_reset();
        iPATTERN = 2'd0;
        run_to(10);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        run_to(20);
        iSTOP = 1'b1;
        tick();
        iSTOP = 1'b0;
        while (cyc <= 45) begin
            check("c_fval", 32'(oFVAL), (cyc <= 36) ? 1 : 0);
            check("c_busy", 32'(oBUSY), (cyc <= 40) ? 1 : 0);
            check("c_frame", oFrame_Cont, (cyc >= 37) ? 1 : 0);
            tick();
        end

        // Start and stop together in IDLE: stop wins.
        run_to(46);
        iSTART = 1'b1;
        iSTOP = 1'b1;
        iGRID = 4'd4;
        tick();
        iSTART = 1'b0;
        iSTOP = 1'b0;
        while (cyc <= 50) begin
            check("d_fval", 32'(oFVAL), 0);
            check("d_busy", 32'(oBUSY), 0);
            if (cyc == 50) iSTART = 1'b1;
            tick();
        end
        iSTART = 1'b0;

        // Blob cell 4 (x 2..3 at y 1 for 2x1 cells), then grid 12 disables it next frame.
        while (cyc <= 110) begin
            rel = (cyc - 51) % 30;
            f = (cyc - 51) / 30;
            frame_pos(rel, fv, lv, x, y);
            exp_data = lv ? 32'h800 : 0;
`ifdef CCD_PATGEN_BLOB_EN
            if (lv && f == 0 && y == 1 && x >= 2 && x < 4) exp_data = 32'h000;
`endif
            check("e_fval", 32'(oFVAL), 32'(fv));
            check("e_lval", 32'(oLVAL), 32'(lv));
            check("e_data", 32'(oDATA), exp_data);
            if (cyc == 60) iGRID = 4'd12;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
